// File: rtl/dem_ctrl_sched_pkg.sv
// Shared mode and direction encodings for the counter sequencing controller.
package dem_ctrl_sched_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL  = 2'b00,
        MODE_AUTO_UP = 2'b01,
        MODE_AUTO_DN = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_MANUAL:  return MODE_AUTO_UP;
            MODE_AUTO_UP: return MODE_AUTO_DN;
            MODE_AUTO_DN: return MODE_HOLD;
            default:      return MODE_MANUAL;
        endcase
    endfunction

endpackage

// File: rtl/dem_ctrl_sched_if.sv
// Button/command bundle between the debouncers, the controller and the counter.
interface dem_ctrl_sched_if #(parameter int CNT_W = 2);
    logic             btn_clr;
    logic             btn_mode;
    logic             btn_up;
    logic             btn_dn;
    logic [4:0]       tg_nn;
    logic [CNT_W-1:0] cnt_q;
    logic             ena_db;
    logic             dir;
    logic             clr;
    logic [1:0]       mode_st;
    logic             sat;

    modport master (
        output btn_clr, btn_mode, btn_up, btn_dn, tg_nn, cnt_q,
        input  ena_db, dir, clr, mode_st, sat
    );

    modport slave (
        input  btn_clr, btn_mode, btn_up, btn_dn, tg_nn, cnt_q,
        output ena_db, dir, clr, mode_st, sat
    );
endinterface

// File: rtl/dem_tick_gen.sv
// Auto-step pacing: prescaler of PRE_DIV cycles, then a 5-bit base-tick counter compared live to tg_nn.
module dem_tick_gen #(
    parameter int PRE_DIV = 1000000
) (
    input  logic       ckht,
    input  logic       rst,
    input  logic       run,
    input  logic       zero,
    input  logic [4:0] tg_nn,
    output logic       step_tick
);
    localparam int PW = (PRE_DIV > 2) ? $clog2(PRE_DIV) : 1;

    logic [PW-1:0] pre;
    logic [4:0]    tick;
    logic          base;

    assign base      = run && (pre == PW'(PRE_DIV - 1));
    assign step_tick = base && !zero && (tick == tg_nn);

    // tick wraps 31->0 naturally, so a lowered tg_nn waits for the wrap instead of firing early
    always_ff @(posedge ckht) begin
        if (!rst || zero) begin
            pre  <= '0;
            tick <= '0;
        end else if (run) begin
            pre <= base ? '0 : pre + 1'b1;
            if (base)
                tick <= (tick == tg_nn) ? 5'd0 : tick + 1'b1;
        end
    end
endmodule

// File: rtl/dem_ctrl_sched.sv
// Button arbiter and auto-step sequencer for the 2-bit counter. Optional macro: SATURATE_EN.
module dem_ctrl_sched
    import dem_ctrl_sched_pkg::*;
#(
    parameter int CNT_W   = 2,
    parameter int MAX_VAL = 3,
    parameter int PRE_DIV = 1000000
) (
    input  logic               ckht,
    input  logic               rst,
    dem_ctrl_sched_if.slave    bus
);
`ifdef SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    mode_e mode;
    logic  ena_r, dir_r, clr_r, sat_r;
    logic  run, zero, step_tick, want, want_dir, limit;

    assign run  = (mode == MODE_AUTO_UP) || (mode == MODE_AUTO_DN);
    assign zero = bus.btn_clr || bus.btn_mode;

    dem_tick_gen #(.PRE_DIV(PRE_DIV)) u_tick (
        .ckht      (ckht),
        .rst       (rst),
        .run       (run),
        .zero      (zero),
        .tg_nn     (bus.tg_nn),
        .step_tick (step_tick)
    );

    // step request after clr/mode have had their chance; up+dn together cancel
    always_comb begin
        want     = 1'b0;
        want_dir = DIR_UP;
        if (!zero) begin
            if (mode == MODE_MANUAL && (bus.btn_up ^ bus.btn_dn)) begin
                want     = 1'b1;
                want_dir = bus.btn_up ? DIR_UP : DIR_DN;
            end else if (step_tick) begin
                want     = 1'b1;
                want_dir = (mode == MODE_AUTO_UP) ? DIR_UP : DIR_DN;
            end
        end
    end

    assign limit = (want_dir == DIR_UP) ? (bus.cnt_q == CNT_W'(MAX_VAL)) : (bus.cnt_q == '0);

    always_ff @(posedge ckht) begin
        if (!rst) begin
            mode  <= MODE_MANUAL;
            ena_r <= 1'b0;
            dir_r <= DIR_UP;
            clr_r <= 1'b0;
            sat_r <= 1'b0;
        end else begin
            ena_r <= 1'b0;
            clr_r <= 1'b0;
            sat_r <= 1'b0;
            if (bus.btn_clr) begin
                clr_r <= 1'b1;
            end else if (bus.btn_mode) begin
                mode <= next_mode(mode);
            end else if (want) begin
                if (SAT_EN && limit) begin
                    sat_r <= 1'b1;
                    if (run)
                        mode <= (mode == MODE_AUTO_UP) ? MODE_AUTO_DN : MODE_AUTO_UP;
                end else begin
                    ena_r <= 1'b1;
                    dir_r <= want_dir;
                end
            end
        end
    end

    assign bus.ena_db  = ena_r;
    assign bus.dir     = dir_r;
    assign bus.clr     = clr_r;
    assign bus.mode_st = mode;
    assign bus.sat     = sat_r;
endmodule

// File: tb/tb_dem_ctrl_sched.sv
// Randomized and directed bench for dem_ctrl_sched against a cycle-count reference model.
module tb_dem_ctrl_sched;
    localparam int PRE = 4;
    localparam int MAXV = 3;
`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic ckht = 1'b0;
    logic rst  = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state: mode as an integer and run cycles since the last zeroing event
    int m_mode = 0;
    int elapsed = 0;
    bit m_ena = 0, m_clr = 0, m_sat = 0, m_dir = 1;

    dem_ctrl_sched_if #(.CNT_W(2)) bus ();

    dem_ctrl_sched #(.CNT_W(2), .MAX_VAL(MAXV), .PRE_DIV(PRE)) dut (
        .ckht (ckht),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 ckht = ~ckht;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc(input bit c, input bit m, input bit u, input bit d);
        bit want, wd;
        bus.btn_clr = c; bus.btn_mode = m; bus.btn_up = u; bus.btn_dn = d;
        @(posedge ckht);
        m_ena = 0; m_clr = 0; m_sat = 0; want = 0; wd = 1;
        if (!rst) begin
            m_mode = 0; m_dir = 1; elapsed = 0;
        end else if (c) begin
            m_clr = 1; elapsed = 0;
        end else if (m) begin
            m_mode = (m_mode + 1) % 4; elapsed = 0;
        end else begin
            if (m_mode == 0 && u != d) begin
                want = 1; wd = u;
            end else if (m_mode == 1 || m_mode == 2) begin
                elapsed++;
                if (elapsed % (PRE * (int'(bus.tg_nn) + 1)) == 0) begin
                    want = 1; wd = (m_mode == 1);
                end
            end
            if (want) begin
                if (SAT && ((wd && int'(bus.cnt_q) == MAXV) || (!wd && bus.cnt_q == 0))) begin
                    m_sat = 1;
                    if (m_mode != 0) m_mode = 3 - m_mode;
                end else begin
                    m_ena = 1; m_dir = wd;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            cyc($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1));
            n_cmp++;
            if (bus.mode_st !== 2'b00 || bus.ena_db !== 1'b0 || bus.clr !== 1'b0 ||
                bus.dir !== 1'b1 || bus.sat !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: mode=%b ena=%b clr=%b dir=%b sat=%b want 00 0 0 1 0",
                         bus.mode_st, bus.ena_db, bus.clr, bus.dir, bus.sat);
            end
        end
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            n_cmp++;
            if (bus.mode_st !== 2'b00 || bus.ena_db !== 1'b0 || bus.clr !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle: mode=%b ena=%b clr=%b want 00 0 0", bus.mode_st, bus.ena_db, bus.clr);
            end
        end
    endtask

    task automatic test_manual;
        bit exp_e[4] = '{1, 0, 1, 0};
        bit exp_d[4] = '{1, 1, 0, 0};
        bit up[4]    = '{1, 0, 0, 1};
        bit dn[4]    = '{0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, up[i], dn[i]);
            n_cmp++;
            if (bus.ena_db !== exp_e[i] || bus.dir !== exp_d[i] || bus.ena_db !== m_ena) begin
                n_bad++;
                $display("FAIL manual_%0d: ena=%b dir=%b want ena=%b dir=%b", i, bus.ena_db, bus.dir, exp_e[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_auto;
        bus.tg_nn = 5'd2;
        for (int md = 1; md <= 2; md++) begin
            int first = -1, cnt = 0;
            cyc(0, 1, 0, 0);
            for (int n = 1; n <= 48; n++) begin
                cyc(0, 0, $urandom_range(0,1), $urandom_range(0,1));
                n_cmp++;
                if (bus.ena_db !== m_ena || (m_ena && bus.dir !== bit'(md == 1))) begin
                    n_bad++;
                    $display("FAIL auto_m%0d_c%0d: ena=%b dir=%b want ena=%b dir=%b",
                             md, n, bus.ena_db, bus.dir, m_ena, md == 1);
                end
                if (bus.ena_db === 1'b1) begin
                    cnt++;
                    if (first < 0) first = n;
                end
            end
            n_cmp++;
            if (first != 12 || cnt != 4 || bus.mode_st !== 2'(md)) begin
                n_bad++;
                $display("FAIL auto_spacing_m%0d: first=%0d count=%0d mode=%b want 12 4 %0d", md, first, cnt, bus.mode_st, md);
            end
        end
        begin
            int cnt = 0;
            cyc(0, 1, 0, 0);
            for (int n = 0; n < 100; n++) begin
                cyc(0, 0, $urandom_range(0,1), $urandom_range(0,1));
                if (bus.ena_db === 1'b1) cnt++;
            end
            n_cmp++;
            if (cnt != 0 || bus.mode_st !== 2'b11) begin
                n_bad++;
                $display("FAIL hold: pulses=%0d mode=%b want 0 11", cnt, bus.mode_st);
            end
        end
    endtask

    task automatic test_priority;
        int first = -1;
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        for (int n = 0; n < 7; n++) cyc(0, 0, 0, 0);
        cyc(1, 1, 1, 0);
        n_cmp++;
        if (bus.clr !== 1'b1 || bus.ena_db !== 1'b0 || bus.mode_st !== 2'b01) begin
            n_bad++;
            $display("FAIL priority: clr=%b ena=%b mode=%b want 1 0 01", bus.clr, bus.ena_db, bus.mode_st);
        end
        for (int n = 1; n <= 50 && first < 0; n++) begin
            cyc(0, 0, 0, 0);
            if (bus.ena_db === 1'b1) first = n;
        end
        n_cmp++;
        if (first != 12) begin
            n_bad++;
            $display("FAIL priority_restart: first step after %0d cycles, want 12", first);
        end
    endtask

    task automatic test_tg_live;
        int first = -1;
        bus.tg_nn = 5'd5;
        cyc(1, 0, 0, 0);
        for (int n = 1; n <= 200 && first < 0; n++) begin
            if (n == 17) bus.tg_nn = 5'd1;
            cyc(0, 0, 0, 0);
            if (bus.ena_db === 1'b1) first = n;
        end
        n_cmp++;
        if (first != 136) begin
            n_bad++;
            $display("FAIL tg_live: first step after %0d cycles, want 136", first);
        end
        cyc(1, 0, 0, 0);
    endtask

    task automatic test_random;
        bus.tg_nn = 5'($urandom_range(0, 3));
        cyc(1, 0, 0, 0);
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            if (SAT) bus.cnt_q = 2'($urandom_range(0, 3));
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            n_cmp++;
            if (bus.mode_st !== 2'(m_mode) || bus.ena_db !== m_ena || bus.clr !== m_clr ||
                bus.sat !== m_sat || (m_ena && bus.dir !== m_dir) || (bus.ena_db && bus.clr)) begin
                n_bad++;
                $display("FAIL random_%0d: mode=%b ena=%b clr=%b sat=%b dir=%b want %0d %b %b %b %b",
                         n, bus.mode_st, bus.ena_db, bus.clr, bus.sat, bus.dir, m_mode, m_ena, m_clr, m_sat, m_dir);
            end
        end
        rst = 1;
        bus.cnt_q = 2'd1;
    endtask

`ifdef SATURATE_EN
    task automatic test_sat;
        rst = 0; cyc(0, 0, 0, 0); rst = 1;
        bus.cnt_q = 2'd3; cyc(0, 0, 1, 0);
        n_cmp++;
        if (bus.ena_db !== 1'b0 || bus.sat !== 1'b1) begin
            n_bad++; $display("FAIL sat_up: ena=%b sat=%b want 0 1", bus.ena_db, bus.sat);
        end
        cyc(0, 0, 0, 0);
        n_cmp++;
        if (bus.sat !== 1'b0) begin
            n_bad++; $display("FAIL sat_clear: sat=%b want 0", bus.sat);
        end
        bus.cnt_q = 2'd0; cyc(0, 0, 0, 1);
        n_cmp++;
        if (bus.ena_db !== 1'b0 || bus.sat !== 1'b1) begin
            n_bad++; $display("FAIL sat_dn: ena=%b sat=%b want 0 1", bus.ena_db, bus.sat);
        end
        bus.tg_nn = 5'd0; bus.cnt_q = 2'd3;
        cyc(0, 1, 0, 0);
        for (int n = 0; n < 4; n++) cyc(0, 0, 0, 0);
        n_cmp++;
        if (bus.mode_st !== 2'b10 || bus.ena_db !== 1'b0 || bus.sat !== 1'b1) begin
            n_bad++; $display("FAIL sat_bounce: mode=%b ena=%b sat=%b want 10 0 1", bus.mode_st, bus.ena_db, bus.sat);
        end
        bus.cnt_q = 2'd1;
        for (int n = 0; n < 4; n++) cyc(0, 0, 0, 0);
        n_cmp++;
        if (bus.ena_db !== 1'b1 || bus.dir !== 1'b0) begin
            n_bad++; $display("FAIL sat_after_bounce: ena=%b dir=%b want 1 0", bus.ena_db, bus.dir);
        end
    endtask
`endif

    initial begin
        bus.btn_clr = 0; bus.btn_mode = 0; bus.btn_up = 0; bus.btn_dn = 0;
        bus.tg_nn = 5'd0; bus.cnt_q = 2'd1;
        #2;
        test_reset;
        test_manual;
        test_auto;
        test_priority;
        test_tg_live;
        test_random;
`ifdef SATURATE_EN
        test_sat;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
